// File: rtl/serial_mod_n_checker.sv
// serial_mod_n_checker
//   Multi-channel serial divisibility checker. Each channel takes one bit
//   per accepted cycle and reports whether the number received so far is
//   divisible by a runtime-programmable divisor D. Bit order is selectable.
//   The value is tracked modulo D only, using compare-and-subtract steps.
//
// Ports
//   clk            clock, all state on its rising edge
//   resetn         synchronous active-low reset (D=3, LSB-first, channels empty)
//   cfg_load       latch cfg_div/cfg_msb_first and empty every channel
//   cfg_div        divisor D
//   cfg_msb_first  1 = MSB-first, 0 = LSB-first
//   vld            per-channel bit valid
//   din            per-channel serial bit
//   clr            per-channel number restart
//   dout           per-channel divisible flag
//   rem            per-channel remainder, channel i at [i*DIV_W +: DIV_W]
//   cfg_err        active divisor is zero
module serial_mod_n_checker #(
    parameter int NCH   = 4,
    parameter int DIV_W = 8
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 cfg_load,
    input  logic [DIV_W-1:0]     cfg_div,
    input  logic                 cfg_msb_first,
    input  logic [NCH-1:0]       vld,
    input  logic [NCH-1:0]       din,
    input  logic [NCH-1:0]       clr,
    output logic [NCH-1:0]       dout,
    output logic [NCH*DIV_W-1:0] rem,
    output logic                 cfg_err
);

    logic [DIV_W-1:0] div_q, div_n;
    logic             msb_q, msb_n;
    logic             err_q, err_n;

    logic [DIV_W-1:0] rem_q [NCH];
    logic [DIV_W-1:0] rem_n [NCH];
    logic [DIV_W-1:0] wgt_q [NCH];
    logic [DIV_W-1:0] wgt_n [NCH];
    logic [NCH-1:0]   started_q, started_n;

    // Working values: a clr alongside vld restarts from the empty state
    // before the new bit is folded in, giving back-to-back numbers.
    logic [DIV_W-1:0] base_rem [NCH];
    logic [DIV_W-1:0] base_wgt [NCH];
    logic [DIV_W:0]   t_sum    [NCH];
    logic [DIV_W:0]   u_dbl    [NCH];

    // 2^0 mod D is 0 when D==1, otherwise 1.
    function automatic logic [DIV_W-1:0] init_wgt(input logic [DIV_W-1:0] d);
        return (d == DIV_W'(1)) ? '0 : DIV_W'(1);
    endfunction

    // Single conditional subtract; valid because callers guarantee t < 2D.
    function automatic logic [DIV_W-1:0] reduce(input logic [DIV_W:0]   t,
                                                 input logic [DIV_W-1:0] d);
        logic [DIV_W:0] dd;
        dd = {1'b0, d};
        return (t >= dd) ? DIV_W'(t - dd) : t[DIV_W-1:0];
    endfunction

    always_comb begin
        div_n = div_q;
        msb_n = msb_q;
        err_n = err_q;
        if (cfg_load) begin
            div_n = cfg_div;
            msb_n = cfg_msb_first;
            err_n = (cfg_div == '0);
        end
    end

    always_comb begin
        started_n = started_q;
        for (int unsigned i = 0; i < NCH; i++) begin
            rem_n[i]    = rem_q[i];
            wgt_n[i]    = wgt_q[i];
            base_rem[i] = clr[i] ? '0 : rem_q[i];
            base_wgt[i] = clr[i] ? init_wgt(div_q) : wgt_q[i];
            if (msb_q) begin
                t_sum[i] = {base_rem[i], din[i]};
            end else begin
                t_sum[i] = {1'b0, base_rem[i]} + (din[i] ? {1'b0, base_wgt[i]} : '0);
            end
            u_dbl[i] = {base_wgt[i], 1'b0};

            if (cfg_load) begin
                rem_n[i]     = '0;
                wgt_n[i]     = init_wgt(cfg_div);
                started_n[i] = 1'b0;
            end else if (vld[i] && !err_q) begin
                rem_n[i]     = reduce(t_sum[i], div_q);
                wgt_n[i]     = reduce(u_dbl[i], div_q);
                started_n[i] = 1'b1;
            end else if (clr[i]) begin
                rem_n[i]     = '0;
                wgt_n[i]     = init_wgt(div_q);
                started_n[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            div_q     <= DIV_W'(3);
            msb_q     <= 1'b0;
            err_q     <= 1'b0;
            started_q <= '0;
            for (int unsigned i = 0; i < NCH; i++) begin
                rem_q[i] <= '0;
                wgt_q[i] <= DIV_W'(1);
            end
        end else begin
            div_q     <= div_n;
            msb_q     <= msb_n;
            err_q     <= err_n;
            started_q <= started_n;
            for (int unsigned i = 0; i < NCH; i++) begin
                rem_q[i] <= rem_n[i];
                wgt_q[i] <= wgt_n[i];
            end
        end
    end

    always_comb begin
        dout    = '0;
        rem     = '0;
        cfg_err = err_q;
        for (int unsigned i = 0; i < NCH; i++) begin
            dout[i]                = started_q[i] && (rem_q[i] == '0) && !err_q;
            rem[i*DIV_W +: DIV_W]  = rem_q[i];
        end
    end

endmodule

// File: tb/tb_serial_mod_n_checker.sv
module tb_serial_mod_n_checker;

    localparam int NCH   = 4;
    localparam int DIV_W = 8;

    logic                 clk;
    logic                 resetn;
    logic                 cfg_load;
    logic [DIV_W-1:0]     cfg_div;
    logic                 cfg_msb_first;
    logic [NCH-1:0]       vld;
    logic [NCH-1:0]       din;
    logic [NCH-1:0]       clr;
    logic [NCH-1:0]       dout;
    logic [NCH*DIV_W-1:0] rem;
    logic                 cfg_err;

    int n_cmp = 0;
    int n_bad = 0;

    // scoreboard state
    int m_rem [NCH];
    int m_wgt [NCH];
    bit m_st  [NCH];
    int m_d;
    bit m_msb;

    serial_mod_n_checker #(.NCH(NCH), .DIV_W(DIV_W)) dut (
        .clk           (clk),
        .resetn        (resetn),
        .cfg_load      (cfg_load),
        .cfg_div       (cfg_div),
        .cfg_msb_first (cfg_msb_first),
        .vld           (vld),
        .din           (din),
        .clr           (clr),
        .dout          (dout),
        .rem           (rem),
        .cfg_err       (cfg_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] rch(input int c);
        return rem[c*DIV_W +: DIV_W];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [7:0] d, input logic m);
        cfg_load = 1'b1; cfg_div = d; cfg_msb_first = m;
        step();
        cfg_load = 1'b0;
    endtask

    task automatic send(input int ch, input logic b);
        vld = '0; din = '0;
        vld[ch] = 1'b1; din[ch] = b;
        step();
        vld = '0; din = '0;
    endtask

    task automatic model_empty(input int d, input bit msb);
        m_d = d; m_msb = msb;
        for (int c = 0; c < NCH; c++) begin
            m_rem[c] = 0; m_wgt[c] = (d == 1) ? 0 : 1; m_st[c] = 0;
        end
    endtask

    task automatic model_step(input logic [NCH-1:0] v, input logic [NCH-1:0] b,
                              input logic [NCH-1:0] cl);
        for (int c = 0; c < NCH; c++) begin
            if (cl[c]) begin
                m_rem[c] = 0; m_wgt[c] = (m_d == 1) ? 0 : 1; m_st[c] = 0;
            end
            if (v[c]) begin
                if (m_msb) m_rem[c] = (2 * m_rem[c] + int'(b[c])) % m_d;
                else begin
                    m_rem[c] = (m_rem[c] + (b[c] ? m_wgt[c] : 0)) % m_d;
                    m_wgt[c] = (2 * m_wgt[c]) % m_d;
                end
                m_st[c] = 1;
            end
        end
    endtask

    task automatic model_check(input string tag);
        for (int c = 0; c < NCH; c++) begin
            check($sformatf("%s_rem%0d", tag, c), 32'(rch(c)), 32'(m_rem[c]));
            check($sformatf("%s_dout%0d", tag, c), 32'(dout[c]),
                  32'(m_st[c] && m_rem[c] == 0));
        end
    endtask

    task automatic random_run(input bit msb);
        logic [NCH-1:0] v, b, cl;
        load(8'd255, msb);
        model_empty(255, msb);
        for (int k = 0; k < 200; k++) begin
            v  = NCH'($urandom);
            b  = NCH'($urandom);
            cl = '0;
            for (int c = 0; c < NCH; c++) cl[c] = ($urandom_range(0, 15) == 0);
            if (k == 100) begin
                // reset mid-stream with traffic present
                resetn = 1'b0; vld = v; din = b; clr = cl;
                step();
                resetn = 1'b1; vld = '0; din = '0; clr = '0;
                model_empty(3, 0);
                check("rst_err", 32'(cfg_err), 32'd0);
                check("rst_dout", 32'(dout), 32'd0);
                check("rst_rem", rem, 32'd0);
                // defaults must behave as D=3 LSB-first
                for (int j = 0; j < 6; j++) begin
                    v = NCH'($urandom); b = NCH'($urandom);
                    vld = v; din = b;
                    step();
                    model_step(v, b, '0);
                    model_check("rst_d3");
                end
                vld = '0; din = '0;
                load(8'd255, msb);
                model_empty(255, msb);
            end else begin
                vld = v; din = b; clr = cl;
                step();
                model_step(v, b, cl);
                model_check(msb ? "rnd_msb" : "rnd_lsb");
            end
        end
        vld = '0; din = '0; clr = '0;
    endtask

    initial begin
        resetn = 1'b0; cfg_load = 1'b0; cfg_div = '0; cfg_msb_first = 1'b0;
        vld = '0; din = '0; clr = '0;
        step(); step();
        resetn = 1'b1;

        // reset state
        check("reset_dout", 32'(dout), 32'd0);
        check("reset_rem", rem, 32'd0);
        check("reset_err", 32'(cfg_err), 32'd0);

        // default D=3 LSB: value 3 on ch0
        send(0, 1'b1);
        check("d3_b1_rem", 32'(rch(0)), 32'd1);
        check("d3_b1_dout", 32'(dout), 32'b0000);
        send(0, 1'b1);
        check("d3_b2_rem", 32'(rch(0)), 32'd0);
        check("d3_b2_dout", 32'(dout), 32'b0001);

        // D=5 MSB: ch2 value 10; vld asserted with the load is ignored
        vld = '1; din = '1;
        load(8'd5, 1'b1);
        vld = '0; din = '0;
        check("d5_load_dout", 32'(dout), 32'd0);
        check("d5_load_rem", rem, 32'd0);
        send(2, 1'b1);
        check("d5_r1", 32'(rch(2)), 32'd1);
        check("d5_o1", 32'(dout), 32'b0000);
        send(2, 1'b0);
        check("d5_r2", 32'(rch(2)), 32'd2);
        check("d5_o2", 32'(dout), 32'b0000);
        send(2, 1'b1);
        check("d5_r3", 32'(rch(2)), 32'd0);
        check("d5_o3", 32'(dout), 32'b0100);
        send(2, 1'b0);
        check("d5_r4", 32'(rch(2)), 32'd0);
        check("d5_o4", 32'(dout), 32'b0100);

        // D=7 LSB: ch0 bits 1,1,1,1,1
        load(8'd7, 1'b0);
        send(0, 1'b1);
        check("d7_r1", 32'(rch(0)), 32'd1);
        send(0, 1'b1);
        check("d7_r2", 32'(rch(0)), 32'd3);
        send(0, 1'b1);
        check("d7_r3", 32'(rch(0)), 32'd0);
        check("d7_o3", 32'(dout), 32'b0001);
        send(0, 1'b1);
        check("d7_r4", 32'(rch(0)), 32'd1);
        check("d7_o4", 32'(dout), 32'b0000);
        send(0, 1'b1);
        check("d7_r5", 32'(rch(0)), 32'd3);

        // D=3 LSB: clr+vld on ch1 alongside independent ch3
        load(8'd3, 1'b0);
        vld = 4'b1010; din = 4'b1000;
        step();
        vld = 4'b0010; din = 4'b0010;
        step();
        check("clr_pre_r1", 32'(rch(1)), 32'd2);
        check("clr_pre_r3", 32'(rch(3)), 32'd1);
        clr = 4'b0010; vld = 4'b1010; din = 4'b1000;
        step();
        check("clr_r1", 32'(rch(1)), 32'd0);
        check("clr_r3", 32'(rch(3)), 32'd0);
        check("clr_dout", 32'(dout), 32'b1010);
        clr = 4'b0010; vld = 4'b0010; din = 4'b0010;
        step();
        check("clr_first1", 32'(rch(1)), 32'd1);
        clr = 4'b0010; vld = '0; din = '0;
        step();
        clr = '0;
        check("clr_only_r1", 32'(rch(1)), 32'd0);
        check("clr_only_dout", 32'(dout), 32'b1000);

        // D=0: error, nothing accepted
        load(8'd0, 1'b0);
        check("d0_err", 32'(cfg_err), 32'd1);
        for (int k = 0; k < 10; k++) begin
            vld = '1; din = 4'($urandom);
            step();
            check("d0_dout", 32'(dout), 32'd0);
            check("d0_rem", rem, 32'd0);
        end
        vld = '0; din = '0;

        // D=1: any bit divisible
        load(8'd1, 1'b0);
        check("d1_err", 32'(cfg_err), 32'd0);
        check("d1_empty", 32'(dout), 32'd0);
        send(0, 1'b1);
        send(1, 1'b0);
        send(2, 1'b1);
        check("d1_dout", 32'(dout), 32'b0111);
        check("d1_rem", rem, 32'd0);

        random_run(1'b0);
        random_run(1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/serial_mod_n_checker.md
Name: serial_mod_n_checker

Overview:
- Multi-channel serial divisibility checker. Each channel receives a binary number one bit per accepted cycle and continuously reports whether the value received so far is divisible by a runtime-programmable divisor D.
- Bit order (LSB-first or MSB-first) is runtime-selectable.
- Generalises the fixed divide-by-3, single-channel, LSB-first checker. Sits between serial front-ends and the status/interrupt logic.

Parameters:
- NCH, 4, number of independent channels.
- DIV_W, 8, divisor width; D range 0..2^DIV_W-1.

Ports:
- clk  in  1  clock
- resetn  in  1  reset
- cfg_load  in  1  load cfg_div/cfg_msb_first; clears all channels
- cfg_div  in  DIV_W  divisor D
- cfg_msb_first  in  1  1 = MSB-first, 0 = LSB-first
- vld  in  NCH  per-channel bit valid
- din  in  NCH  per-channel serial bit
- clr  in  NCH  per-channel number restart
- dout  out  NCH  divisible flag per channel
- rem  out  NCH*DIV_W  current remainder per channel; channel i at bits [i*DIV_W +: DIV_W]
- cfg_err  out  1  active divisor is 0

Behaviour:
- Reset: resetn synchronous, active-low; clock clk; all state on posedge clk.
- Reset values and channel state:
  - On reset: D=3, LSB-first, cfg_err=0.
  - Every channel is empty: rem=0, wgt=1, started=0, so dout=0.
  - Reset mid-stream discards all partial numbers.
- Per-channel state:
  - rem: DIV_W bits, invariant rem < D when D>0.
  - wgt: DIV_W bits, equals 2^k mod D in LSB mode, where k is the number of bits accepted.
  - started: 1 bit.
- Empty-channel initial values: rem=0, started=0, wgt = (D==1) ? 0 : 1.
- Accept: a channel accepts a bit on a clock edge where vld[i]=1, cfg_load=0 and cfg_err=0.
- MSB-first update:
  - t = 2*rem + din, computed in DIV_W+1 bits.
  - rem' = (t >= D) ? t-D : t. A single conditional subtract is sufficient because t < 2D.
- LSB-first update:
  - t = rem + (din ? wgt : 0), computed in DIV_W+1 bits.
  - rem' = (t >= D) ? t-D : t.
  - u = 2*wgt; wgt' = (u >= D) ? u-D : u.
- No divider or modulo operator; all arithmetic is compare and subtract.
- started' = 1 on every accepted bit.
- Outputs: dout[i] = started[i] & (rem[i]==0) & ~cfg_err, decoded from registers.
- Latency: a bit accepted at edge k is reflected in dout/rem immediately after edge k. There is no extra pipeline stage.
- Empty channel (no bits since clear): dout=0.
- clr[i] without vld[i]: channel returns to empty at the edge.
- clr[i] and vld[i] in the same cycle:
  - Channel restarts and accepts din as the first bit of the new number.
  - Result: rem = din mod D, started=1, wgt' computed from the initial wgt.
  - Supports back-to-back numbers with no bubble.
- cfg_load=1:
  - D and mode are latched from cfg_div/cfg_msb_first.
  - cfg_err' = (cfg_div==0).
  - All channels go to empty, with wgt initialised using the new D.
  - Any vld/clr asserted in the same cycle is ignored.
- cfg_err=1 (D=0): no bits accepted and every dout=0 until a cfg_load with nonzero D.
- D=1: any accepted bit gives rem=0, dout=1.
- No bit-length limit: the value is tracked modulo D only, so arbitrarily long streams never overflow.
- Channels are fully independent; any vld pattern across channels is legal in any cycle.
- cfg_div/cfg_msb_first are sampled only on cfg_load; changing them otherwise has no effect.

Test Plan:
- Reset defaults (D=3, LSB), ch0 bits 1,1 (value 3) -> rem 1 then 0; dout 0 then 1. Ch1-3 stay dout=0.
- cfg_load D=5 MSB; ch2 bits 1,0,1,0 (value 10) -> rem 1,2,0,0; dout 0,0,1,1.
- cfg_load D=7 LSB; ch0 bits 1,1,1 -> rem 1,3,0 with dout=1. Fourth bit 1 (value 15) -> rem 1, dout 0, wgt wraps 4->1.
- D=3 LSB; ch1 holding rem=2; clr=1 with vld=1, din=0 -> rem 0, dout 1. Same cycle, ch3 with vld only is unaffected by ch1's clr.
- cfg_load D=0 -> cfg_err=1; 10 cycles of vld on all channels -> all dout=0, rem=0. Then cfg_load D=1 -> any single bit gives dout=1.
- Stream 200 random bits per channel with D=255 in each mode, including resetn pulsed low mid-stream -> rem matches a scoreboard value mod D every cycle. After reset: D=3, LSB, all dout=0.
